// File: rtl/deck_shoe_pkg.sv
// Shared constants for the deck shoe: FSM encodings, parameter defaults, default seed and LFSR step.
package deck_shoe_pkg;

    localparam int DECK_SIZE_DEF = 52;
    localparam int NUM_RANKS_DEF = 13;
    localparam int LFSR_W_DEF    = 6;

    localparam logic [5:0] DEFAULT_SEED = 6'h2A;
    localparam logic [3:0] NO_CARD      = 4'd0;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_DRAW      = 3'd2;
    localparam logic [2:0] S_DONE_WAIT = 3'd3;
    localparam logic [2:0] S_DEAL      = 3'd4;
    localparam logic [2:0] S_DEAL_WAIT = 3'd5;

    // Fibonacci x^6+x^5+1, shift left; maximal period 63, never reaches zero from a nonzero state.
    function automatic logic [5:0] lfsr6_next(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

endpackage

// File: rtl/deck_shoe_lfsr6.sv
// 6-bit maximal-length LFSR; load has priority over step, and a zero load is replaced by the default seed.
module lfsr6
    import deck_shoe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       step,
    output logic [5:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= DEFAULT_SEED;
        end else if (load) begin
            value <= (load_val == 6'd0) ? DEFAULT_SEED : load_val;
        end else if (step) begin
            value <= lfsr6_next(value);
        end
    end

endmodule

// File: rtl/deck_shoe.sv
// Card shoe: seeded Fisher-Yates shuffle, then one card per 4-phase card_start/card_ready handshake
// (card_ready one cycle after S_DEAL, held until card_start drops). DECK_STATS_EN adds cards_left/shuffle_cycles.
module deck_shoe
    import deck_shoe_pkg::*;
#(
    parameter int DECK_SIZE = DECK_SIZE_DEF,
    parameter int NUM_RANKS = NUM_RANKS_DEF,
    parameter int LFSR_W    = LFSR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    input  logic              shuffle_start,
    output logic              shuffle_ready,
    input  logic              card_start,
    output logic              card_ready,
    output logic [3:0]        card,
    output logic              card_overflow
`ifdef DECK_STATS_EN
    ,
    output logic [5:0]        cards_left,
    output logic [11:0]       shuffle_cycles
`endif
);

    localparam logic [5:0] DS6       = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_SLOT = 6'(DECK_SIZE - 1);
    localparam logic [3:0] TOP_RANK  = 4'(NUM_RANKS);

    logic [2:0] state;
    logic [5:0] idx;
    logic [5:0] ptr;
    logic [3:0] rank_ctr;
    logic [3:0] mem [DECK_SIZE];

    logic       lfsr_load;
    logic       lfsr_step;
    logic [5:0] lfsr_val;
    logic [5:0] lfsr_nxt;
    logic [5:0] cand;
    logic       take;

    assign lfsr_load = (state == S_IDLE) && shuffle_start;
    assign lfsr_step = (state == S_DRAW);
    assign lfsr_nxt  = lfsr6_next(lfsr_val);
    assign cand      = lfsr_nxt - 6'd1;
    // Candidates above the current slot are rejected, which keeps the draw uniform over 0..idx.
    assign take      = (state == S_DRAW) && (cand <= idx);

    lfsr6 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (6'(seed)),
        .step     (lfsr_step),
        .value    (lfsr_val)
    );

    // The shoe itself is never reset; ptr alone decides whether its contents are dealable.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[idx] <= rank_ctr;
        end else if (take) begin
            mem[idx]  <= mem[cand];
            mem[cand] <= mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            shuffle_ready <= 1'b1;
            card_ready    <= 1'b0;
            card          <= NO_CARD;
            card_overflow <= 1'b0;
            ptr           <= DS6;
            idx           <= 6'd0;
            rank_ctr      <= 4'd1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (shuffle_start) begin
                        shuffle_ready <= 1'b0;
                        idx           <= 6'd0;
                        rank_ctr      <= 4'd1;
                        state         <= S_INIT;
                    end else if (card_start) begin
                        state <= S_DEAL;
                    end
                end
                S_INIT: begin
                    rank_ctr <= (rank_ctr == TOP_RANK) ? 4'd1 : rank_ctr + 4'd1;
                    if (idx == LAST_SLOT) begin
                        state <= S_DRAW;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                S_DRAW: begin
                    if (take) begin
                        if (idx == 6'd1) begin
                            ptr           <= 6'd0;
                            card_overflow <= 1'b0;
                            state         <= S_DONE_WAIT;
                        end else begin
                            idx <= idx - 6'd1;
                        end
                    end
                end
                S_DONE_WAIT: begin
                    if (!shuffle_start) begin
                        shuffle_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                S_DEAL: begin
                    if (ptr < DS6) begin
                        card <= mem[ptr];
                        ptr  <= ptr + 6'd1;
                    end else begin
                        card          <= NO_CARD;
                        card_overflow <= 1'b1;
                    end
                    card_ready <= 1'b1;
                    state      <= S_DEAL_WAIT;
                end
                S_DEAL_WAIT: begin
                    if (!card_start) begin
                        card_ready <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DECK_STATS_EN
    assign cards_left = DS6 - ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shuffle_cycles <= 12'd0;
        end else if (lfsr_load) begin
            shuffle_cycles <= 12'd0;
        end else if ((state == S_INIT) || (state == S_DRAW)) begin
            shuffle_cycles <= shuffle_cycles + 12'd1;
        end
    end
`endif

endmodule

// File: tb/tb_deck_shoe.sv
// Directed bench for deck_shoe: reference Fisher-Yates model, handshake timing, exhaustion and reset abort.
module tb_deck_shoe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] seed = 6'd0;
    logic       shuffle_start = 1'b0;
    logic       shuffle_ready;
    logic       card_start = 1'b0;
    logic       card_ready;
    logic [3:0] card;
    logic       card_overflow;
`ifdef DECK_STATS_EN
    logic [5:0]  cards_left;
    logic [11:0] shuffle_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_deck [52];
    int         exp_cycles;
    logic [3:0] got [53];
    logic       got_ovf [53];

    always #5 clk = ~clk;

    deck_shoe dut (
        .clk           (clk),
        .rst           (rst),
        .seed          (seed),
        .shuffle_start (shuffle_start),
        .shuffle_ready (shuffle_ready),
        .card_start    (card_start),
        .card_ready    (card_ready),
        .card          (card),
        .card_overflow (card_overflow)
`ifdef DECK_STATS_EN
        ,
        .cards_left     (cards_left),
        .shuffle_cycles (shuffle_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference shuffle: same LFSR sequence, rejection sampling and swap order as the shoe should use.
    task automatic build_model(input logic [5:0] s);
        logic [5:0] l;
        logic [3:0] t;
        int         i;
        int         j;
        l = (s == 6'd0) ? 6'h2A : s;
        for (int k = 0; k < 52; k++) exp_deck[k] = 4'((k % 13) + 1);
        exp_cycles = 52;
        i = 51;
        while (i >= 1) begin
            l = {l[4:0], l[5] ^ l[4]};
            exp_cycles++;
            j = int'(l) - 1;
            if (j <= i) begin
                t = exp_deck[i];
                exp_deck[i] = exp_deck[j];
                exp_deck[j] = t;
                i--;
            end
        end
    endtask

    task automatic do_shuffle(input logic [5:0] s);
        int n;
        seed = s;
        shuffle_start = 1'b1;
        tick(1);
        shuffle_start = 1'b0;
        n = 0;
        while (!shuffle_ready && n < 4000) begin
            tick(1);
            n++;
        end
        if (!shuffle_ready) chk("shuffle_timeout", shuffle_ready, 1);
    endtask

    task automatic deal(output logic [3:0] c, output logic o);
        int n;
        card_start = 1'b1;
        n = 0;
        while (!card_ready && n < 8) begin
            tick(1);
            n++;
        end
        if (!card_ready) chk("deal_ack_timeout", card_ready, 1);
        c = card;
        o = card_overflow;
        card_start = 1'b0;
        n = 0;
        while (card_ready && n < 8) begin
            tick(1);
            n++;
        end
        if (card_ready) chk("deal_release_timeout", card_ready, 0);
    endtask

    task automatic deal_all_and_compare(input string tag);
        for (int k = 0; k < 52; k++) deal(got[k], got_ovf[k]);
        for (int k = 0; k < 52; k++) chk(tag, got[k], exp_deck[k]);
        chk("last_card_ovf", got_ovf[51], 0);
    endtask

    initial begin
        logic [3:0] c0;
        logic [3:0] c;
        logic       o;
        int         hist [14];
        int         n;

        tick(2);
        chk("rst_shuffle_ready", shuffle_ready, 1);
        chk("rst_card_ready", card_ready, 0);
        chk("rst_card", card, 0);
        chk("rst_overflow", card_overflow, 0);
`ifdef DECK_STATS_EN
        chk("rst_cards_left", cards_left, 0);
`endif
        rst = 1'b0;
        tick(1);

        // Never shuffled: behaves as an empty shoe.
        deal(c, o);
        chk("preshuffle_card", c, 0);
        chk("preshuffle_ovf", o, 1);

        // Held shuffle_start: ready drops next cycle, returns only after release.
        build_model(6'b001010);
        seed = 6'b001010;
        shuffle_start = 1'b1;
        tick(1);
        chk("shuffle_ready_drop", shuffle_ready, 0);
        tick(3400);
        chk("shuffle_ready_held", shuffle_ready, 0);
        shuffle_start = 1'b0;
        tick(1);
        chk("shuffle_ready_rise", shuffle_ready, 1);
        chk("shuffle_clears_ovf", card_overflow, 0);
`ifdef DECK_STATS_EN
        chk("stats_cards_full", cards_left, 52);
        chk("stats_shuffle_cycles", shuffle_cycles, 32'(exp_cycles));
`endif

        // First card with explicit handshake timing.
        card_start = 1'b1;
        tick(1);
        chk("ack_not_early", card_ready, 0);
        tick(1);
        chk("ack_latency", card_ready, 1);
        c0 = card;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("ack_hold", card_ready, 1);
            chk("card_stable", card, c0);
        end
        card_start = 1'b0;
        tick(1);
        chk("ack_release", card_ready, 0);
        chk("card_hold_after", card, c0);
        got[0] = c0;
        for (int k = 1; k < 53; k++) deal(got[k], got_ovf[k]);

        for (int k = 0; k < 14; k++) hist[k] = 0;
        for (int k = 0; k < 52; k++) begin
            chk("order_seed0a", got[k], exp_deck[k]);
            hist[got[k]]++;
        end
        for (int r = 1; r <= 13; r++) chk("rank_count", hist[r], 4);
        chk("card52_ovf", got_ovf[51], 0);
        chk("card53_card", got[52], 0);
        chk("card53_ovf", got_ovf[52], 1);
        chk("ovf_sticky", card_overflow, 1);

        // Same seed again, then seed 0 against the default seed.
        do_shuffle(6'b001010);
        chk("reshuffle_clears_ovf", card_overflow, 0);
        deal_all_and_compare("order_repeat");
`ifdef DECK_STATS_EN
        chk("stats_cards_empty", cards_left, 0);
`endif
        build_model(6'h2A);
        do_shuffle(6'd0);
        deal_all_and_compare("order_seed_zero");

        // Both requests together: shuffle first, pending card is the new top card.
        build_model(6'h15);
        seed = 6'h15;
        shuffle_start = 1'b1;
        card_start = 1'b1;
        tick(1);
        chk("both_shuffle_first", shuffle_ready, 0);
        chk("both_no_ack", card_ready, 0);
        tick(2);
        shuffle_start = 1'b0;
        n = 0;
        while (!shuffle_ready && n < 4000) begin
            tick(1);
            n++;
        end
        chk("both_shuffle_done", shuffle_ready, 1);
        chk("both_ack_after_shuffle", card_ready, 0);
        n = 0;
        while (!card_ready && n < 8) begin
            tick(1);
            n++;
        end
        chk("both_card_ack", card_ready, 1);
        chk("both_card_top", card, exp_deck[0]);
        card_start = 1'b0;
        tick(2);

        // Async reset while the shuffle is in its draw phase.
        seed = 6'h07;
        shuffle_start = 1'b1;
        tick(1);
        shuffle_start = 1'b0;
        tick(60);
        chk("mid_draw_busy", shuffle_ready, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_shuffle_ready", shuffle_ready, 1);
        chk("async_card", card, 0);
        chk("async_card_ready", card_ready, 0);
        chk("async_overflow", card_overflow, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        deal(c, o);
        chk("post_abort_card", c, 0);
        chk("post_abort_ovf", o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
